multicycle_controller: RTL

// - Multicycle successor to the single-cycle main decoder.
// - Same opcode set: R/I/LW/SW/BR/LUI/JAL/JALR.
// - Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
// - Uses ready handshakes to instruction and data memory.
// - Sits between the IR/opcode field and the datapath muxes, register file, PC and memories.
// - Adds a memory-timeout trap and a retired-instruction counter.

---
 rtl/multicycle_controller.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Multicycle main controller: sequences R/I/LW/SW/BR/LUI/JAL/JALR through
// FETCH/DECODE/EXEC/MEM/WB with memory-ready handshakes, a timeout trap and a
// retired-instruction counter. Define MULTICYCLE_CTRL_HALT_EN to make ECALL halt.
module multicycle_controller #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned TO_CNT_W    = 8,
    parameter int unsigned INSTRET_W   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    output logic                 imem_req,
    output logic                 ir_write,
    output logic                 dmem_req,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 alu_src,
    output logic                 mem_to_reg,
    output logic                 reg_write,
    output logic [1:0]           alu_op,
    output logic                 branch,
    output logic                 jal,
    output logic                 jalr,
    output logic                 pc_write,
    output logic                 trap,
    output logic [1:0]           trap_cause,
    output logic [INSTRET_W-1:0] instret
`ifdef MULTICYCLE_CTRL_HALT_EN
    ,
    output logic                 halted
`endif
);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
`ifdef MULTICYCLE_CTRL_HALT_EN
    localparam logic [6:0] OP_SYS  = 7'b1110011;
`endif

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_IMEM_TO = 2'b10;
    localparam logic [1:0] CAUSE_DMEM_TO = 2'b11;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
`ifdef MULTICYCLE_CTRL_HALT_EN
        ,
        S_HALT
`endif
    } state_e;

    typedef struct packed {
        logic       src;
        logic [1:0] op;
    } alu_ctl_t;

    // Same ALU operand/operation table as the single-cycle decoder.
    function automatic alu_ctl_t alu_decode(input logic [6:0] op);
        alu_ctl_t c;
        case (op)
            OP_R:                   c = '{src: 1'b0, op: 2'b10};
            OP_I:                   c = '{src: 1'b1, op: 2'b10};
            OP_LW, OP_SW:           c = '{src: 1'b1, op: 2'b00};
            OP_BR:                  c = '{src: 1'b0, op: 2'b01};
            OP_LUI, OP_JAL, OP_JALR: c = '{src: 1'b1, op: 2'b11};
            default:                c = '{src: 1'b0, op: 2'b00};
        endcase
        return c;
    endfunction

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_LUI, OP_JAL, OP_JALR: return 1'b1;
            default:                                                  return 1'b0;
        endcase
    endfunction

    state_e                 state_q, state_d;
    logic [6:0]             op_q, op_d;
    logic [TO_CNT_W-1:0]    cnt_q, cnt_d;
    logic [INSTRET_W-1:0]   instret_q, instret_d;
    logic [1:0]             cause_q, cause_d;
    logic                   retire;
    logic                   wait_expired;
    alu_ctl_t               alu_ctl;

    assign alu_ctl      = alu_decode(op_q);
    assign wait_expired = (cnt_q == TO_CNT_W'(MEM_TIMEOUT));
    assign instret      = instret_q;
    assign trap_cause   = cause_q;

    // NOTE: state registers use non-blocking assignments; the async reset
    // clears every register so the counters and trap cause are defined at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            cnt_q     <= '0;
            instret_q <= '0;
            cause_q   <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            instret_q <= instret_d;
            cause_q   <= cause_d;
        end
    end

    // NOTE: every output and next-state value gets a default before the case,
    // so no path through this block can infer a latch.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        cause_d    = cause_q;
        retire     = 1'b0;
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        dmem_req   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_op     = 2'b00;
        branch     = 1'b0;
        jal        = 1'b0;
        jalr       = 1'b0;
        pc_write   = 1'b0;
        trap       = 1'b0;
`ifdef MULTICYCLE_CTRL_HALT_EN
        halted     = 1'b0;
`endif

        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_DECODE;
                end else if (wait_expired) begin
                    cause_d = CAUSE_IMEM_TO;
                    state_d = S_TRAP;
                end else begin
                    cnt_d = cnt_q + TO_CNT_W'(1);
                end
            end

            S_DECODE: begin
                op_d = opcode;
`ifdef MULTICYCLE_CTRL_HALT_EN
                if (opcode == OP_SYS) begin
                    retire  = 1'b1;
                    state_d = S_HALT;
                end else
`endif
                if (!is_legal(opcode)) begin
                    cause_d = CAUSE_ILLEGAL;
                    state_d = S_TRAP;
                end else begin
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                alu_src = alu_ctl.src;
                alu_op  = alu_ctl.op;
                branch  = (op_q == OP_BR);
                jal     = (op_q == OP_JAL);
                jalr    = (op_q == OP_JALR);
                cnt_d   = '0;
                if (op_q == OP_LW || op_q == OP_SW) begin
                    state_d = S_MEM;
                end else if (op_q == OP_BR) begin
                    pc_write = 1'b1;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end

            S_MEM: begin
                dmem_req  = 1'b1;
                mem_read  = (op_q == OP_LW);
                mem_write = (op_q == OP_SW);
                alu_src   = 1'b1;
                alu_op    = 2'b00;
                // Ready is tested before the timeout so a last-cycle response still completes.
                if (dmem_ready) begin
                    cnt_d = '0;
                    if (op_q == OP_SW) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_expired) begin
                    cause_d = CAUSE_DMEM_TO;
                    state_d = S_TRAP;
                end else begin
                    cnt_d = cnt_q + TO_CNT_W'(1);
                end
            end

            S_WB: begin
                alu_src    = alu_ctl.src;
                alu_op     = alu_ctl.op;
                jal        = (op_q == OP_JAL);
                jalr       = (op_q == OP_JALR);
                mem_to_reg = (op_q == OP_LW);
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end

            S_TRAP: begin
                trap = 1'b1;
            end

`ifdef MULTICYCLE_CTRL_HALT_EN
            S_HALT: begin
                halted = 1'b1;
            end
`endif

            default: begin
                state_d = S_FETCH;
            end
        endcase

        instret_d = retire ? instret_q + INSTRET_W'(1) : instret_q;

        // Strobes are forced low while reset is held so an aborted access ends in the same cycle.
        if (reset) begin
            imem_req   = 1'b0;
            ir_write   = 1'b0;
            dmem_req   = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            alu_src    = 1'b0;
            mem_to_reg = 1'b0;
            reg_write  = 1'b0;
            alu_op     = 2'b00;
            branch     = 1'b0;
            jal        = 1'b0;
            jalr       = 1'b0;
            pc_write   = 1'b0;
            trap       = 1'b0;
`ifdef MULTICYCLE_CTRL_HALT_EN
            halted     = 1'b0;
`endif
        end
    end

endmodule
